// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Arbiter states, grant encoding and the read data returned on a timed-out access.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    // Wide enough for any practical DATA_W; cast down at the use site.
    localparam logic [63:0] ERR_RDATA = 64'h0;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts busy cycles without a memory acknowledge.
// tc is high in the last cycle the request may stay outstanding.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data access.
// Data has fixed priority; a request with no acknowledge is aborted and flagged in err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    arb_state_e        state, state_nxt;
    gnt_e              gnt;
    logic              busy, tc, done, timed_out;
    logic [DATA_W-1:0] done_rdata;

    // A requester seeing its ready this cycle is not re-granted until the next.
    logic d_elig, i_elig;
    assign d_elig = d_req & ~d_ready;
    assign i_elig = if_req & ~if_ready;

    assign busy      = (state != IDLE);
    assign done      = busy & (mem_ack | tc);
    assign timed_out = busy & ~mem_ack & tc;
    assign done_rdata = timed_out ? DATA_W'(ERR_RDATA) : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = GNT_NONE;
        case (state)
            IDLE: begin
                if (d_elig) begin
                    gnt       = GNT_D;
                    state_nxt = BUSY_D;
                end else if (i_elig) begin
                    gnt       = GNT_I;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || tc)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    arb_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clear (gnt != GNT_NONE),
        .enable(busy & ~mem_ack),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (gnt)
                GNT_D: begin
                    mem_req   <= 1'b1;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
                GNT_I: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
                default: ;
            endcase
            if (done) begin
                mem_req <= 1'b0;
                if (state == BUSY_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= done_rdata;
                end else begin
                    d_ready <= 1'b1;
                    // A completed store leaves the last load result visible.
                    if (!mem_we || timed_out)
                        d_rdata <= done_rdata;
                end
                if (timed_out)
                    err <= 1'b1;
            end
        end
    end

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and data-memory port. It sits between the CPU core (fetch and memory stages) and the mother_board memory. It arbitrates with fixed data-over-fetch priority and runs a req/ack handshake to memory. It also raises a pipeline stall and flags a sticky error when memory fails to respond.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width of all ports.
TIMEOUT_CYC, 64, max cycles mem_req may stay high without mem_ack before abort; must be >=1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  ADDR_W  fetch address; stable while if_req
if_rdata  out  DATA_W  fetched instruction; valid when if_ready
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid when d_ready and the access was a load
d_ready  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  memory completion, one cycle
stall  out  1  pipeline stall request
err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE. All registered outputs 0: mem_*, if_ready, d_ready, if_rdata, d_rdata, err, timeout counter.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Eligible requester = req high AND its ready not high this cycle. This blocks re-grant in the cycle a requester sees ready.
  - d eligible -> BUSY_D. Else if eligible -> BUSY_I. Else stay IDLE.
  - On grant edge: mem_req<=1; mem_addr/mem_we/mem_wdata<=granted port values. Fetch forces mem_we=0, mem_wdata=0.
- BUSY_x:
  - mem_req held high and mem_* held constant until mem_ack.
  - On mem_ack in cycle M: at edge M->M+1, mem_req<=0, state<=IDLE, x_ready<=1 for exactly cycle M+1.
  - Loads and fetches capture mem_rdata into x_rdata at that edge. Stores leave d_rdata unchanged.
  - Minimum fetch latency: req sampled in cycle N, mem_req visible N+1, ack at N+1 gives ready at N+2.
  - IDLE in M+1 may grant the other requester in that same cycle. Back-to-back: next mem_req at M+2.
- mem_ack while IDLE is ignored (no ready, no state change).
- Timeout:
  - Counter clears on grant and increments each BUSY cycle without mem_ack.
  - When count == TIMEOUT_CYC-1 and no ack: at the next edge, mem_req<=0, state<=IDLE, x_ready pulse with x_rdata<=0, err<=1.
  - err stays set until reset. A store that times out still pulses d_ready.
  - Ack arriving in the terminal cycle wins: normal completion, no err.
- stall (combinational) = (if_req & ~if_ready) | (d_req & ~d_ready).
- Simultaneous if_req and d_req in IDLE: data granted first. Fetch is granted in the IDLE cycle where d_ready pulses, if still requesting.
- Reset mid-transaction: mem_req drops asynchronously and the transaction is abandoned without ready. The memory model must tolerate an abandoned request.
- Widths: counter width $clog2(TIMEOUT_CYC+1). No address arithmetic is performed.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D), grant encoding (GNT_NONE/GNT_I/GNT_D), ERR_RDATA constant = 0.
- Sub-module arb_timeout_counter (clear, enable, terminal-count output, TIMEOUT_CYC parameter).
- Arbitration and FSM stay in mem_arbiter.

Test Plan:
1. Single fetch, memory acks 1 cycle after mem_req. if_req, if_addr=0x0000_0040 at cycle 0 -> mem_req/mem_addr=0x40 at cycle 1. Ack with mem_rdata=0x2002_0005 at cycle 1 -> if_ready=1, if_rdata=0x2002_0005 at cycle 2. stall high cycles 0-1, low at 2.
2. Simultaneous if_req (addr 0x44) and d_req load (addr 0x100), memory acks 2 cycles after mem_req with mem_rdata 0x1234_5678 -> data served first, d_rdata=0x1234_5678. Fetch mem_req at 0x44 begins the cycle after d_ready.
3. Store d_we=1, d_addr=0x200, d_wdata=0xCAFE_F00D -> mem_we=1, mem_wdata=0xCAFE_F00D until ack. d_ready pulses. d_rdata keeps its prior value.
4. TIMEOUT_CYC=4, no ack -> mem_req high exactly 4 cycles, then drops. d_ready pulses with d_rdata=0 and err=1. err stays 1 through later successful accesses.
5. Assert reset while in BUSY_D -> mem_req, d_ready and err are 0 immediately (async). A stale mem_ack in the following IDLE is ignored.
6. Ack arriving in the terminal timeout cycle -> normal completion with mem_rdata, err stays 0.
